muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that extends the CPU datapath beyond the single-cycle ALU with MULT, MULTU, DIV and DIVU. It sits beside the ALU in the execute stage and owns the HI/LO result registers. It runs a start/busy/done handshake so the control unit can stall while an operation iterates. Operands and results are WIDTH bits; each operation takes a fixed WIDTH+1 cycles, except divide-by-zero, which finishes early.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the control unit (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Multiply is radix-2 shift-add (LSB first), divide is restoring (MSB first);
// both run on sign-stripped magnitudes, and the signs are re-applied when the
// result is written. Divide-by-zero skips the iteration entirely.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;   // product/quotient must be negated
  logic               r_neg_rem;   // remainder must be negated (dividend sign)
  logic               r_dz;        // divide-by-zero pending in FINISH
  logic [WIDTH-1:0]   r_opb;       // multiplicand, divisor, or raw dividend on /0
  // Upper WIDTH+1 bits: running product high half or partial remainder.
  // Lower WIDTH bits: remaining multiplier bits or quotient being built.
  logic [2*WIDTH:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH:0]   w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes, one iteration step, and the final sign fix-up.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    w_acc_step  = r_acc;
    w_a_neg     = bus.op[0] & bus.a[WIDTH-1];
    w_b_neg     = bus.op[0] & bus.b[WIDTH-1];
    w_a_mag     = w_a_neg ? -bus.a : bus.a;
    w_b_mag     = w_b_neg ? -bus.b : bus.b;
    w_b_zero    = (bus.b == '0);

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right by one.
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The extra top bit of the difference is the exact borrow.
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};

    if (!r_is_div) begin
      w_acc_step = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
    end else if (!w_div_diff[WIDTH+1]) begin
      w_acc_step = {w_div_diff[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_step = {w_div_shift, r_acc[WIDTH-2:0], 1'b0};
    end

    w_prod = r_neg_res ? -r_acc[2*WIDTH-1:0]     : r_acc[2*WIDTH-1:0];
    w_quo  = r_neg_res ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and HI/LO result registers.
  // NOTE: all state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= bus.op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            if (!bus.op[1]) begin
              r_acc   <= {{(WIDTH+1){1'b0}}, w_b_mag};
              r_opb   <= w_a_mag;
              r_dz    <= 1'b0;
              r_state <= S_CALC;
            end else if (w_b_zero) begin
              // Nothing to iterate: keep the raw dividend for HI.
              r_acc   <= '0;
              r_opb   <= bus.a;
              r_dz    <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_acc   <= {{(WIDTH+1){1'b0}}, w_a_mag};
              r_opb   <= w_b_mag;
              r_dz    <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (bus.cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= S_FINISH;
            end
          end
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!bus.cancel) begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_hi       <= r_opb;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else if (r_is_div) begin
              r_hi       <= w_rem;
              r_lo       <= w_quo;
              r_div_zero <= 1'b0;
            end else begin
              r_hi       <= w_prod[2*WIDTH-1:WIDTH];
              r_lo       <= w_prod[WIDTH-1:0];
              r_div_zero <= 1'b0;
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance driven with directed
// and $urandom operations, checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic clk = 1'b0;
  logic rst32_n;
  logic rst8_n;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) if32 ();
  muldiv_unit_if #(.WIDTH(8))  if8  ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32_n), .bus(if32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8_n),  .bus(if8.slave));

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] exp_hi, exp_lo;
  logic        exp_dz;
  int          exp_lat;
  logic [63:0] prev_hi, prev_lo;
  logic        prev_dz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on wide integers.
  function automatic void model(input int w, input logic [1:0] op,
                                input logic [63:0] a_in, input logic [63:0] b_in,
                                output logic [63:0] hi, output logic [63:0] lo,
                                output logic dz, output int lat);
    logic [63:0]         mask, a, b;
    logic signed [129:0] sa, sb, res;
    logic [129:0]        tmp;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = $signed({66'b0, a});
    sb   = $signed({66'b0, b});
    if (op[0]) begin
      if (a[w-1]) sa = sa - (130'sd1 <<< w);
      if (b[w-1]) sb = sb - (130'sd1 <<< w);
    end
    dz  = 1'b0;
    lat = w + 1;
    if (!op[1]) begin
      res = sa * sb;
      tmp = res;
      lo  = tmp[63:0] & mask;
      tmp = tmp >> w;
      hi  = tmp[63:0] & mask;
    end else if (b == 64'd0) begin
      hi  = a;
      lo  = mask;
      dz  = 1'b1;
      lat = 1;
    end else begin
      tmp = sa / sb;
      lo  = tmp[63:0] & mask;
      tmp = sa % sb;
      hi  = tmp[63:0] & mask;
    end
  endfunction

  function automatic logic [63:0] o_hi(input int w);
    if (w == 32) return {32'b0, if32.hi};
    return {56'b0, if8.hi};
  endfunction

  function automatic logic [63:0] o_lo(input int w);
    if (w == 32) return {32'b0, if32.lo};
    return {56'b0, if8.lo};
  endfunction

  function automatic logic o_busy(input int w);
    return (w == 32) ? if32.busy : if8.busy;
  endfunction

  function automatic logic o_done(input int w);
    return (w == 32) ? if32.done : if8.done;
  endfunction

  function automatic logic o_dz(input int w);
    return (w == 32) ? if32.div_zero : if8.div_zero;
  endfunction

  task automatic drive(input int w, input logic st, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      if32.start = st; if32.op = op; if32.a = a[31:0]; if32.b = b[31:0];
    end else begin
      if8.start = st;  if8.op = op;  if8.a = a[7:0];   if8.b = b[7:0];
    end
  endtask

  task automatic set_cancel(input int w, input logic c);
    if (w == 32) if32.cancel = c;
    else         if8.cancel  = c;
  endtask

  task automatic save_prev();
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    prev_dz = exp_dz;
  endtask

  task automatic restore_prev();
    exp_hi = prev_hi;
    exp_lo = prev_lo;
    exp_dz = prev_dz;
  endtask

  // Present an operation at the current negedge; it is accepted at the next
  // posedge, after which the inputs are scrambled.
  task automatic issue(input int w, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input string tag);
    model(w, op, a, b, exp_hi, exp_lo, exp_dz, exp_lat);
    drive(w, 1'b1, op, a, b);
    @(negedge clk);
    drive(w, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    check({tag, "/busy_after_accept"}, 64'(o_busy(w)), 64'd1);
  endtask

  // Wait (bounded) for done, then check latency and the result.
  task automatic finish_op(input int w, input string tag);
    int cyc = 0;
    while (!o_done(w) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"},      64'(cyc),        64'(exp_lat));
    check({tag, "/busy_at_done"}, 64'(o_busy(w)),  64'd0);
    check({tag, "/hi"},           o_hi(w),         exp_hi);
    check({tag, "/lo"},           o_lo(w),         exp_lo);
    check({tag, "/div_zero"},     64'(o_dz(w)),    64'(exp_dz));
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [63:0] r_a, r_b;
    int          done_seen;

    rst32_n = 1'b0;
    rst8_n  = 1'b0;
    drive(32, 1'b0, 2'b00, 64'd0, 64'd0);
    drive(8,  1'b0, 2'b00, 64'd0, 64'd0);
    set_cancel(32, 1'b0);
    set_cancel(8,  1'b0);
    exp_hi = 64'd0; exp_lo = 64'd0; exp_dz = 1'b0;

    #12;
    check("reset/busy",     64'(if32.busy),     64'd0);
    check("reset/done",     64'(if32.done),     64'd0);
    check("reset/hi",       64'(if32.hi),       64'd0);
    check("reset/lo",       64'(if32.lo),       64'd0);
    check("reset/div_zero", 64'(if32.div_zero), 64'd0);
    @(negedge clk);
    rst32_n = 1'b1;
    rst8_n  = 1'b1;
    @(negedge clk);

    // Largest unsigned product; done must last exactly one cycle.
    issue(32, OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "multu_max");
    finish_op(32, "multu_max");
    check("multu_max/hi_const", o_hi(32), 64'hFFFF_FFFE);
    check("multu_max/lo_const", o_lo(32), 64'h0000_0001);
    @(negedge clk);
    check("multu_max/done_one_cycle", 64'(if32.done), 64'd0);

    // Signed multiply, then a signed divide issued in its done cycle.
    issue(32, OP_MULT, 64'hFFFF_FFF9, 64'd6, "mult_neg");
    finish_op(32, "mult_neg");
    check("mult_neg/lo_const", o_lo(32), 64'hFFFF_FFD6);
    issue(32, OP_DIV, 64'hFFFF_FFF9, 64'd2, "div_neg_b2b");
    finish_op(32, "div_neg_b2b");
    check("div_neg_b2b/lo_const", o_lo(32), 64'hFFFF_FFFD);
    check("div_neg_b2b/hi_const", o_hi(32), 64'hFFFF_FFFF);

    // Divide by zero, then a normal divide clearing the flag.
    @(negedge clk);
    issue(32, OP_DIVU, 64'd100, 64'd0, "divu_zero");
    finish_op(32, "divu_zero");
    check("divu_zero/flag_const", 64'(if32.div_zero), 64'd1);
    issue(32, OP_DIVU, 64'd100, 64'd7, "divu_100_7");
    finish_op(32, "divu_100_7");
    check("divu_100_7/lo_const", o_lo(32), 64'd14);

    // Signed overflow case.
    issue(32, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, "div_ovf");
    finish_op(32, "div_ovf");
    check("div_ovf/lo_const", o_lo(32), 64'h8000_0000);

    // Cancel while in FINISH (divide by zero path).
    @(negedge clk);
    save_prev();
    issue(32, OP_DIVU, 64'd55, 64'd0, "cancel_fin");
    set_cancel(32, 1'b1);
    @(negedge clk);
    set_cancel(32, 1'b0);
    check("cancel_fin/done", 64'(if32.done),     64'd0);
    check("cancel_fin/busy", 64'(if32.busy),     64'd0);
    check("cancel_fin/hi",   64'(if32.hi),       prev_hi);
    check("cancel_fin/lo",   64'(if32.lo),       prev_lo);
    check("cancel_fin/dz",   64'(if32.div_zero), 64'(prev_dz));
    restore_prev();

    // Cancel mid-CALC.
    @(negedge clk);
    issue(32, OP_MULTU, 64'd3, 64'd5, "cancel_calc");
    repeat (9) @(negedge clk);
    set_cancel(32, 1'b1);
    @(negedge clk);
    set_cancel(32, 1'b0);
    check("cancel_calc/busy", 64'(if32.busy), 64'd0);
    check("cancel_calc/done", 64'(if32.done), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if32.done) done_seen++;
    end
    check("cancel_calc/no_done", 64'(done_seen), 64'd0);
    check("cancel_calc/hi",      64'(if32.hi),   prev_hi);
    check("cancel_calc/lo",      64'(if32.lo),   prev_lo);
    restore_prev();

    // Random operations on the 32-bit unit, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom);
      r_a  = {32'b0, $urandom};
      r_b  = {32'b0, $urandom};
      case ($urandom_range(0, 5))
        0: r_b = 64'd0;
        1: r_b = 64'hFFFF_FFFF;
        2: r_a = 64'h8000_0000;
        3: r_b = {32'b0, 32'($urandom_range(1, 20))};
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(32, r_op, r_a, r_b, "rand32");
      finish_op(32, "rand32");
    end

    // 8-bit instance: directed divide, then reset in the middle of CALC.
    @(negedge clk);
    issue(8, OP_DIVU, 64'd200, 64'd13, "w8_divu");
    finish_op(8, "w8_divu");
    check("w8_divu/lo_const", o_lo(8), 64'd15);
    check("w8_divu/hi_const", o_hi(8), 64'd5);

    @(negedge clk);
    issue(8, OP_MULTU, 64'd17, 64'd9, "w8_reset");
    repeat (3) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    check("w8_reset/busy",     64'(if8.busy),     64'd0);
    check("w8_reset/done",     64'(if8.done),     64'd0);
    check("w8_reset/hi",       64'(if8.hi),       64'd0);
    check("w8_reset/lo",       64'(if8.lo),       64'd0);
    check("w8_reset/div_zero", 64'(if8.div_zero), 64'd0);
    @(negedge clk);
    rst8_n = 1'b1;
    issue(8, OP_DIVU, 64'd200, 64'd13, "w8_after_reset");
    finish_op(8, "w8_after_reset");

    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom);
      r_a  = 64'($urandom_range(0, 255));
      r_b  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) r_b = 64'd0;
      if ($urandom_range(0, 4) == 0) begin r_a = 64'h80; r_b = 64'hFF; end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(8, r_op, r_a, r_b, "rand8");
      finish_op(8, "rand8");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
